// File: rtl/scan_dump_ctrl_if.sv
// Request, word-stream and commit handshakes between the scan-dump controller and DFT readout.
// master = controller side, slave = requester/readout side.
interface scan_dump_ctrl_if #(
  parameter int WORD_W = 32,
  parameter int CH_W   = 1
);
  logic              op_val;
  logic [CH_W-1:0]   op_ch;
  logic              op_ack;
  logic [WORD_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              commit;
  logic              commit_ack;

  modport master (
    input  op_val, op_ch, out_ready, commit_ack,
    output op_ack, out_data, out_valid, out_last, commit
  );

  modport slave (
    output op_val, op_ch, out_ready, commit_ack,
    input  op_ack, out_data, out_valid, out_last, commit
  );
endinterface

// File: rtl/scan_dump_ctrl.sv
// Freezes the DUT, shifts one scan chain out LSB-first and packs it into WORD_W-bit stream words.
// Define SCAN_RESTORE_EN to recirculate the chain so the dump is non-destructive.
module scan_dump_ctrl #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 32,
  parameter int NUM_CH    = 2
) (
  input  logic                clk,
  input  logic                reset,
  scan_dump_ctrl_if.master    bus,
  output logic                dut_hold,
  output logic                busy,
  output logic [NUM_CH-1:0]   scan_en,
  input  logic [NUM_CH-1:0]   scan_out_i,
  output logic [NUM_CH-1:0]   scan_in_o
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int WP_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, OUT, COMMIT} state_t;

  state_t            state, state_nxt;
  logic [CH_W-1:0]   ch;
  logic [CNT_W-1:0]  bit_cnt;
  logic [WP_W-1:0]   wpos;
  logic [WORD_W-1:0] word;
  logic              ack_q;
  logic [NUM_CH-1:0] sel;
  logic              sample_bit;
  logic              word_done;
  logic              last_bit;
  logic              chain_done;

  // An out-of-range channel selects nothing: no shift enable and zero data.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_CH; i++) sel[i] = (32'(ch) == i);
  end

  assign sample_bit = |(sel & scan_out_i);
  assign word_done  = (wpos == WP_W'(WORD_W - 1));
  assign last_bit   = (bit_cnt == CNT_W'(CHAIN_LEN - 1));
  assign chain_done = (bit_cnt == CNT_W'(CHAIN_LEN));

  assign bus.op_ack   = ack_q;
  assign bus.out_data = word;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    busy          = 1'b0;
    dut_hold      = 1'b0;
    scan_en       = '0;
    scan_in_o     = '0;
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    bus.commit    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.op_val) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy     = 1'b1;
        dut_hold = 1'b1;
        scan_en  = sel;
`ifdef SCAN_RESTORE_EN
        scan_in_o = sel & scan_out_i;
`else
        scan_in_o = '0;
`endif
        if (word_done || last_bit) state_nxt = OUT;
      end
      OUT: begin
        busy          = 1'b1;
        dut_hold      = 1'b1;
        bus.out_valid = 1'b1;
        bus.out_last  = chain_done;
        if (bus.out_ready) state_nxt = chain_done ? COMMIT : SHIFT;
      end
      COMMIT: begin
        busy       = 1'b1;
        dut_hold   = 1'b1;
        bus.commit = 1'b1;
        if (bus.commit_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ch      <= '0;
      bit_cnt <= '0;
      wpos    <= '0;
      word    <= '0;
      ack_q   <= 1'b0;
    end else begin
      ack_q <= (state == IDLE) && bus.op_val;
      case (state)
        IDLE: begin
          if (bus.op_val) begin
            ch      <= bus.op_ch;
            bit_cnt <= '0;
            wpos    <= '0;
            word    <= '0;
          end
        end
        SHIFT: begin
          word[wpos] <= sample_bit;
          bit_cnt    <= bit_cnt + 1'b1;
          wpos       <= wpos + 1'b1;
        end
        OUT: begin
          // Cleared only after handshake so the word stays stable under backpressure.
          if (bus.out_ready && !chain_done) begin
            wpos <= '0;
            word <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
